// File: rtl/byte_2_word_pack.sv
// Byte-to-word packer: gathers N_BYTES bytes into one word behind valid/ready
// handshakes on both sides, with flush to close a partial word.
module byte_2_word_pack #(
    parameter int BYTE_W    = 8,
    parameter int N_BYTES   = 2,
    parameter bit FIRST_LSB = 1'b1,
    parameter int CNT_W     = $clog2(N_BYTES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ce,
    input  logic                        byte_dv,
    input  logic [BYTE_W-1:0]           byte_data,
    output logic                        byte_rdy,
    input  logic                        flush,
    output logic                        word_dv,
    input  logic                        word_rdy,
    output logic [BYTE_W*N_BYTES-1:0]   word,
    output logic [CNT_W-1:0]            word_nbytes,
    output logic                        word_partial
);

    localparam int               WORD_W = BYTE_W * N_BYTES;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(N_BYTES - 1);

    logic [N_BYTES-1:0][BYTE_W-1:0] acc;
    logic [N_BYTES-1:0][BYTE_W-1:0] acc_byte;
    logic [CNT_W-1:0]               cnt;
    logic [CNT_W-1:0]               cnt_byte;
    logic [CNT_W-1:0]               lane_sel;
    logic                           out_vld;
    logic [WORD_W-1:0]              out_word;
    logic [CNT_W-1:0]               out_n;
    logic                           out_part;
    logic                           flush_pend;
    logic                           active;

    logic                           out_free;
    logic                           byte_acc;
    logic                           word_take;
    logic                           full_done;
    logic                           flush_req;
    logic                           has_part;
    logic                           close_now;
    logic [WORD_W-1:0]              full_word;
    logic [WORD_W-1:0]              part_word;

    // byte_rdy is held low until the first clock after reset release
    assign out_free  = !out_vld | word_rdy;
    assign byte_rdy  = active & ce & !flush_pend & ((cnt < LAST) | out_free);
    assign byte_acc  = byte_dv & byte_rdy;
    assign word_dv   = out_vld & ce;
    assign word_take = word_dv & word_rdy;
    assign lane_sel  = FIRST_LSB ? cnt : (LAST - cnt);

    assign word         = out_word;
    assign word_nbytes  = out_n;
    assign word_partial = out_part;

    // Accumulator and fill count after this cycle's byte, before any flush
    always_comb begin
        acc_byte  = acc;
        cnt_byte  = cnt;
        full_done = 1'b0;
        if (byte_acc) begin
            for (int i = 0; i < N_BYTES; i++) begin
                if (lane_sel == CNT_W'(i)) begin
                    acc_byte[i] = byte_data;
                end
            end
            if (cnt == LAST) begin
                full_done = 1'b1;
                cnt_byte  = '0;
            end else begin
                cnt_byte = cnt + CNT_W'(1);
            end
        end
    end

    assign full_word = acc_byte;

    // Partial word keeps only the lanes already filled; the rest read as zero
    always_comb begin
        part_word = '0;
        for (int i = 0; i < N_BYTES; i++) begin
            if (FIRST_LSB ? (CNT_W'(i) < cnt_byte)
                          : (CNT_W'(N_BYTES - 1 - i) < cnt_byte)) begin
                part_word[i*BYTE_W +: BYTE_W] = acc_byte[i];
            end
        end
    end

    assign flush_req = (flush & ce) | flush_pend;
    assign has_part  = flush_req & (cnt_byte != '0);
    assign close_now = has_part & out_free & ce;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    // A completing byte and a partial close are mutually exclusive: after a
    // completing byte the fill count is zero, so a same-cycle flush is a no-op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            cnt        <= '0;
            out_vld    <= 1'b0;
            out_word   <= '0;
            out_n      <= '0;
            out_part   <= 1'b0;
            flush_pend <= 1'b0;
        end else if (ce) begin
            flush_pend <= has_part & !out_free;
            if (full_done) begin
                out_vld  <= 1'b1;
                out_word <= full_word;
                out_n    <= CNT_W'(N_BYTES);
                out_part <= 1'b0;
                cnt      <= '0;
                acc      <= '0;
            end else if (close_now) begin
                out_vld  <= 1'b1;
                out_word <= part_word;
                out_n    <= cnt_byte;
                out_part <= 1'b1;
                cnt      <= '0;
                acc      <= '0;
            end else begin
                acc <= acc_byte;
                cnt <= cnt_byte;
                if (word_take) begin
                    out_vld <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_byte_2_word_pack.sv
// Scoreboard bench for byte_2_word_pack: three instances (2x8 LSB-first,
// 4x8 MSB-first, 4x8 LSB-first) driven from one stimulus thread.
module tb_byte_2_word_pack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       ce;
    logic       byte_dv   [3];
    logic [7:0] byte_data [3];
    logic       flush     [3];
    logic       word_rdy  [3];

    logic        rdy_a, rdy_b, rdy_c;
    logic        dv_a, dv_b, dv_c;
    logic        part_a, part_b, part_c;
    logic [15:0] word_a;
    logic [31:0] word_b, word_c;
    logic [1:0]  nb_a;
    logic [2:0]  nb_b, nb_c;

    byte_2_word_pack #(.BYTE_W(8), .N_BYTES(2), .FIRST_LSB(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ce(ce), .byte_dv(byte_dv[0]), .byte_data(byte_data[0]),
        .byte_rdy(rdy_a), .flush(flush[0]), .word_dv(dv_a), .word_rdy(word_rdy[0]),
        .word(word_a), .word_nbytes(nb_a), .word_partial(part_a)
    );

    byte_2_word_pack #(.BYTE_W(8), .N_BYTES(4), .FIRST_LSB(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .ce(ce), .byte_dv(byte_dv[1]), .byte_data(byte_data[1]),
        .byte_rdy(rdy_b), .flush(flush[1]), .word_dv(dv_b), .word_rdy(word_rdy[1]),
        .word(word_b), .word_nbytes(nb_b), .word_partial(part_b)
    );

    byte_2_word_pack #(.BYTE_W(8), .N_BYTES(4), .FIRST_LSB(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .ce(ce), .byte_dv(byte_dv[2]), .byte_data(byte_data[2]),
        .byte_rdy(rdy_c), .flush(flush[2]), .word_dv(dv_c), .word_rdy(word_rdy[2]),
        .word(word_c), .word_nbytes(nb_c), .word_partial(part_c)
    );

    typedef struct {
        logic [31:0] w;
        int          n;
        bit          p;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [7:0] m_bytes [3][4];
    int         m_cnt   [3];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nb_of(int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic bit lsb_of(int d);
        return (d == 1) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic obs_rdy(int d);
        case (d)
            0:       return rdy_a;
            1:       return rdy_b;
            default: return rdy_c;
        endcase
    endfunction

    function automatic logic obs_dv(int d);
        case (d)
            0:       return dv_a;
            1:       return dv_b;
            default: return dv_c;
        endcase
    endfunction

    function automatic logic [31:0] obs_word(int d);
        case (d)
            0:       return {16'h0000, word_a};
            1:       return word_b;
            default: return word_c;
        endcase
    endfunction

    function automatic logic [2:0] obs_nb(int d);
        case (d)
            0:       return {1'b0, nb_a};
            1:       return nb_b;
            default: return nb_c;
        endcase
    endfunction

    function automatic logic obs_part(int d);
        case (d)
            0:       return part_a;
            1:       return part_b;
            default: return part_c;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected word from the bytes the bench sent, placed by lane order
    function automatic logic [31:0] pack(int d, int n);
        logic [31:0] w;
        int          lane;
        w = '0;
        for (int i = 0; i < n; i++) begin
            lane = lsb_of(d) ? i : (nb_of(d) - 1 - i);
            w    = w | (32'(m_bytes[d][i]) << (8 * lane));
        end
        return w;
    endfunction

    task automatic push_exp(input int d, input logic [31:0] w, input int n, input bit p);
        exp_t e;
        e.w = w;
        e.n = n;
        e.p = p;
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int d, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '{w: 32'h0, n: 0, p: 1'b0};
        case (d)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic model_accept(input int d, input logic [7:0] b);
        m_bytes[d][m_cnt[d]] = b;
        m_cnt[d]++;
        if (m_cnt[d] == nb_of(d)) begin
            push_exp(d, pack(d, nb_of(d)), nb_of(d), 1'b0);
            m_cnt[d] = 0;
        end
    endtask

    task automatic model_flush(input int d);
        if (m_cnt[d] > 0) begin
            push_exp(d, pack(d, m_cnt[d]), m_cnt[d], 1'b1);
        end
        m_cnt[d] = 0;
    endtask

    // Scoreboard: every handshaken output word must match the queue head
    exp_t mon_e;
    bit   mon_ok;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (obs_dv(d) && word_rdy[d]) begin
                    pop_exp(d, mon_e, mon_ok);
                    if (!mon_ok) begin
                        checkOutput($sformatf("d%0d_extra_word_dv", d), 64'(obs_dv(d)), 64'd0);
                    end else begin
                        checkOutput($sformatf("d%0d_word", d), 64'(obs_word(d)), 64'(mon_e.w));
                        checkOutput($sformatf("d%0d_nbytes", d), 64'(obs_nb(d)), 64'(mon_e.n));
                        checkOutput($sformatf("d%0d_partial", d), 64'(obs_part(d)), 64'(mon_e.p));
                    end
                end
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int d, input logic [7:0] b);
        bit got;
        got          = 1'b0;
        byte_data[d] = b;
        byte_dv[d]   = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (obs_rdy(d)) got = 1'b1;
        end
        checkOutput($sformatf("d%0d_byte_rdy_wait", d), 64'(got), 64'd1);
        @(posedge clk);
        #1;
        byte_dv[d] = 1'b0;
        if (got) model_accept(d, b);
    endtask

    task automatic pulse_flush(input int d);
        flush[d] = 1'b1;
        @(posedge clk);
        #1;
        flush[d] = 1'b0;
        model_flush(d);
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (q0.size() + q1.size() + q2.size() == 0) break;
            wait_cycles(1);
        end
        checkOutput("drain_pending", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    endtask

    task automatic expect_quiet(input int d, input string tag, input int n);
        repeat (n) begin
            @(negedge clk);
            checkOutput(tag, 64'(obs_dv(d)), 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c0;
        rst_n = 1'b0;
        ce    = 1'b1;
        for (int d = 0; d < 3; d++) begin
            byte_dv[d]   = 1'b0;
            byte_data[d] = 8'h00;
            flush[d]     = 1'b0;
            word_rdy[d]  = 1'b1;
            m_cnt[d]     = 0;
        end

        #2;
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("d%0d_rst_word_dv", d), 64'(obs_dv(d)), 64'd0);
            checkOutput($sformatf("d%0d_rst_word", d), 64'(obs_word(d)), 64'd0);
            checkOutput($sformatf("d%0d_rst_nbytes", d), 64'(obs_nb(d)), 64'd0);
            checkOutput($sformatf("d%0d_rst_partial", d), 64'(obs_part(d)), 64'd0);
            checkOutput($sformatf("d%0d_rst_byte_rdy", d), 64'(obs_rdy(d)), 64'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cycles(2);

        $display("[TB] full words, two-byte packer");
        applyStimulus(0, 8'h11);
        applyStimulus(0, 8'h22);
        @(negedge clk);
        checkOutput("full_latency_dv", 64'(dv_a), 64'd1);
        @(posedge clk);
        #1;
        applyStimulus(0, 8'h33);
        applyStimulus(0, 8'h44);
        c0 = cyc;
        for (int i = 1; i <= 6; i++) applyStimulus(0, 8'(i * 8'h13));
        checkOutput("throughput_cycles", 64'(cyc - c0), 64'd6);
        drain();

        $display("[TB] MSB-first four-byte packer");
        applyStimulus(1, 8'hA1);
        applyStimulus(1, 8'hB2);
        applyStimulus(1, 8'hC3);
        applyStimulus(1, 8'hD4);
        drain();

        $display("[TB] partial flush, LSB-first four-byte packer");
        applyStimulus(2, 8'h01);
        applyStimulus(2, 8'h02);
        applyStimulus(2, 8'h03);
        pulse_flush(2);
        drain();
        pulse_flush(2);
        expect_quiet(2, "empty_flush_dv", 3);

        $display("[TB] output back-pressure");
        word_rdy[0] = 1'b0;
        applyStimulus(0, 8'h10);
        applyStimulus(0, 8'h20);
        applyStimulus(0, 8'h30);
        byte_data[0] = 8'h40;
        byte_dv[0]   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_byte_rdy", 64'(rdy_a), 64'd0);
            checkOutput("bp_word_hold", 64'(word_a), 64'h2010);
            checkOutput("bp_word_dv", 64'(dv_a), 64'd1);
        end
        @(posedge clk);
        #1;
        word_rdy[0] = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_rdy", 64'(rdy_a), 64'd1);
        @(posedge clk);
        #1;
        byte_dv[0] = 1'b0;
        model_accept(0, 8'h40);
        @(negedge clk);
        checkOutput("bp_reload_dv", 64'(dv_a), 64'd1);
        @(posedge clk);
        #1;
        applyStimulus(0, 8'h50);
        pulse_flush(0);
        drain();

        $display("[TB] flush while output busy");
        word_rdy[0] = 1'b0;
        applyStimulus(0, 8'h55);
        applyStimulus(0, 8'h66);
        applyStimulus(0, 8'h77);
        pulse_flush(0);
        byte_data[0] = 8'h88;
        byte_dv[0]   = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("pend_byte_rdy", 64'(rdy_a), 64'd0);
            checkOutput("pend_word_hold", 64'(word_a), 64'h6655);
        end
        @(posedge clk);
        #1;
        byte_dv[0]  = 1'b0;
        word_rdy[0] = 1'b1;
        drain();

        $display("[TB] flush with nothing buffered");
        pulse_flush(0);
        expect_quiet(0, "null_flush_dv", 3);
        applyStimulus(0, 8'h5A);
        flush[0] = 1'b1;
        applyStimulus(0, 8'h5B);
        flush[0] = 1'b0;
        model_flush(0);
        drain();
        expect_quiet(0, "complete_flush_dv", 3);

        $display("[TB] clock enable freeze");
        word_rdy[0] = 1'b0;
        applyStimulus(0, 8'h01);
        applyStimulus(0, 8'h02);
        applyStimulus(0, 8'h03);
        ce           = 1'b0;
        byte_data[0] = 8'h99;
        byte_dv[0]   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("ce_byte_rdy", 64'(rdy_a), 64'd0);
            checkOutput("ce_word_dv", 64'(dv_a), 64'd0);
            checkOutput("ce_word_hold", 64'(word_a), 64'h0201);
        end
        @(posedge clk);
        #1;
        ce          = 1'b1;
        byte_dv[0]  = 1'b0;
        word_rdy[0] = 1'b1;
        applyStimulus(0, 8'h04);
        drain();

        $display("[TB] reset mid-word");
        applyStimulus(0, 8'hAB);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_word_dv", 64'(dv_a), 64'd0);
        checkOutput("midrst_word", 64'(word_a), 64'd0);
        checkOutput("midrst_nbytes", 64'(nb_a), 64'd0);
        checkOutput("midrst_partial", 64'(part_a), 64'd0);
        checkOutput("midrst_byte_rdy", 64'(rdy_a), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) m_cnt[d] = 0;
        expect_quiet(0, "postrst_word_dv", 3);
        applyStimulus(0, 8'hC1);
        applyStimulus(0, 8'hC2);
        drain();

        wait_cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
